// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch state encoding,
// instruction format constants and the NOP/bubble word.
package if_fetch_stage_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    // The decoder treats an all-zero word as "no control asserted".
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold, load and bubble control; bubble wins
// over load, and a bubble clears every field, so it looks like a NOP downstream.
module if_fetch_stage_if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                bubble,
    input  logic [INSTR_W-1:0]  next_instr,
    input  logic [PC_WIDTH-1:0] next_pc_plus1,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPC_W-1:0]    opcode,
    output logic [PC_WIDTH-1:0] pc_plus1,
    output logic                valid
);

    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            instr    <= NOP_INSTR;
            pc_plus1 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= next_instr;
            pc_plus1 <= next_pc_plus1;
            valid    <= 1'b1;
        end
    end

    assign opcode = instr[OPC_MSB:OPC_LSB];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, stall/redirect handling.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/bubble counters.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [OPC_W-1:0]    if_id_opcode,
    output logic [PC_WIDTH-1:0] if_id_pc_plus1,
    output logic                if_id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]         perf_fetched,
    output logic [15:0]         perf_bubbles
`endif
);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pending;
    logic [INSTR_W-1:0]  hold_buf;
    logic                load;
    logic                bubble;
    logic [INSTR_W-1:0]  next_instr;
    logic [PC_WIDTH-1:0] next_pc_plus1;

    assign pc_inc    = pc + PC_WIDTH'(1);
    // Reset drops req in the same cycle so the memory side abandons its transaction.
    assign imem_req  = !reset && (state != HOLD);
    assign imem_addr = pc;

    // In HOLD the PC has already stepped past the buffered word, so pc is its pc+1.
    always_comb begin
        load          = 1'b0;
        bubble        = 1'b0;
        next_instr    = hold_buf;
        next_pc_plus1 = pc;
        case (state)
            FETCH: begin
                if (redirect)
                    bubble = 1'b1;
                else if (imem_ack && !stall) begin
                    load          = 1'b1;
                    next_instr    = imem_rdata;
                    next_pc_plus1 = pc_inc;
                end else if (!imem_ack && !stall)
                    bubble = 1'b1;
            end
            DISCARD: bubble = redirect || !stall;
            HOLD: begin
                if (redirect)
                    bubble = 1'b1;
                else if (!stall)
                    load = 1'b1;
            end
            default: bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            pending  <= '0;
            hold_buf <= NOP_INSTR;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect)
                            pc <= redirect_pc;
                        else begin
                            pc <= pc_inc;
                            if (stall) begin
                                hold_buf <= imem_rdata;
                                state    <= HOLD;
                            end
                        end
                    end else if (redirect) begin
                        // Address must stay put until the in-flight read is acked.
                        pending <= redirect_pc;
                        state   <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        pc    <= redirect ? redirect_pc : pending;
                        state <= FETCH;
                    end else if (redirect)
                        pending <= redirect_pc;
                end
                HOLD: begin
                    if (redirect) begin
                        hold_buf <= NOP_INSTR;
                        pc       <= redirect_pc;
                        state    <= FETCH;
                    end else if (!stall)
                        state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    if_fetch_stage_if_id_reg #(.PC_WIDTH(PC_WIDTH)) u_if_id_reg (
        .clock         (clock),
        .reset         (reset),
        .load          (load),
        .bubble        (bubble),
        .next_instr    (next_instr),
        .next_pc_plus1 (next_pc_plus1),
        .instr         (if_id_instr),
        .opcode        (if_id_opcode),
        .pc_plus1      (if_id_pc_plus1),
        .valid         (if_id_valid)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (load && perf_fetched != 16'hFFFF)
                perf_fetched <= perf_fetched + 16'd1;
            if (bubble && perf_bubbles != 16'hFFFF)
                perf_bubbles <= perf_bubbles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, a reset-mid-discard sequence
// and a randomized run, all cross-checked against a queue-based fetch model.
module tb_if_fetch_stage;

    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          reset, stall, redirect, imem_ack, imem_req, if_id_valid;
    logic [PW-1:0] redirect_pc, imem_addr, if_id_pc_plus1;
    logic [15:0]   imem_rdata, if_id_instr;
    logic [2:0]    if_id_opcode;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    if_fetch_stage #(.PC_WIDTH(PW), .RESET_PC(8'h00)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_opcode   (if_id_opcode),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid)
    );

    typedef struct {
        bit        rst, st, rd;
        bit [7:0]  rpc;
        bit        ak;
        bit        req;
        bit [7:0]  addr;
        bit [15:0] instr;
        bit        valid;
        bit [7:0]  pc1;
    } vec_t;

    typedef struct {
        bit [15:0] instr;
        bit [7:0]  pc1;
    } ent_t;

    // Reference model: next fetch address, pending-drop flag and a queue of
    // words fetched during a stall that still wait to enter IF/ID.
    bit [7:0]  m_pc, m_tgt;
    bit        m_drop;
    ent_t      held[$];
    bit [15:0] m_instr;
    bit        m_valid;
    bit [7:0]  m_pc1;

    bit        obs_req;
    bit [7:0]  obs_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t v(bit rst, bit st, bit rd, bit [7:0] rpc, bit ak,
                               bit req, bit [7:0] addr, bit [15:0] instr, bit valid, bit [7:0] pc1);
        vec_t r;
        r.rst = rst; r.st = st; r.rd = rd; r.rpc = rpc; r.ak = ak;
        r.req = req; r.addr = addr; r.instr = instr; r.valid = valid; r.pc1 = pc1;
        return r;
    endfunction

    task automatic m_bubble();
        m_instr = 16'h0; m_valid = 1'b0; m_pc1 = 8'h0;
    endtask

    // One clock: drive at negedge, check req/addr, advance model, check IF/ID after the edge.
    task automatic step(input bit rst, input bit st, input bit rd, input bit [7:0] rpc,
                        input bit ak, input bit rnd);
        bit        exp_req;
        bit [15:0] rdat;
        ent_t      e;
        @(negedge clock);
        reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
        #1;
        rdat       = rnd ? 16'($urandom) : 16'h6000 + 16'(imem_addr);
        imem_rdata = rdat;
        imem_ack   = rnd ? (imem_req && ($urandom_range(0, 1) == 1)) : ak;
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        exp_req  = !rst && (held.size() == 0);
        chk("model_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("model_addr", 32'(imem_addr), 32'(m_pc));
        if (rst) begin
            held.delete(); m_drop = 1'b0; m_pc = 8'h00; m_tgt = 8'h00; m_bubble();
        end else if (held.size() != 0) begin
            if (rd) begin held.delete(); m_pc = rpc; m_bubble(); end
            else if (!st) begin
                e = held.pop_front();
                m_instr = e.instr; m_valid = 1'b1; m_pc1 = e.pc1;
            end
        end else if (m_drop) begin
            if (rd) m_tgt = rpc;
            if (imem_ack) begin m_pc = m_tgt; m_drop = 1'b0; end
            if (rd || !st) m_bubble();
        end else if (rd) begin
            if (imem_ack) m_pc = rpc;
            else begin m_drop = 1'b1; m_tgt = rpc; end
            m_bubble();
        end else if (imem_ack) begin
            if (st) held.push_back('{rdat, 8'(m_pc + 8'd1)});
            else begin m_instr = rdat; m_valid = 1'b1; m_pc1 = 8'(m_pc + 8'd1); end
            m_pc = 8'(m_pc + 8'd1);
        end else if (!st) m_bubble();
        @(posedge clock);
        #1;
        chk("model_ifid", {4'h0, if_id_instr, if_id_valid, if_id_pc_plus1, if_id_opcode},
            {4'h0, m_instr, m_valid, m_pc1, m_instr[15:13]});
    endtask

    task automatic chk_row(input string n, input bit er, input bit [7:0] ea,
                           input bit [15:0] ei, input bit ev, input bit [7:0] ep);
        bit [15:0] t;
        t = ei;
        chk({n, "_req"}, 32'(obs_req), 32'(er));
        if (er) chk({n, "_addr"}, 32'(obs_addr), 32'(ea));
        chk({n, "_instr"}, 32'(if_id_instr), 32'(ei));
        chk({n, "_opcode"}, 32'(if_id_opcode), 32'(t[15:13]));
        chk({n, "_valid"}, 32'(if_id_valid), 32'(ev));
        chk({n, "_pc1"}, 32'(if_id_pc_plus1), 32'(ep));
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        m_pc = 0; m_tgt = 0; m_drop = 0; m_instr = 0; m_valid = 0; m_pc1 = 0;

        //                 rst st rd rpc    ak   req addr   instr     v  pc1
        tbl.push_back(v(1, 0, 0, 8'h00, 0,   0, 8'h00, 16'h0000, 0, 8'h00));
        tbl.push_back(v(1, 0, 0, 8'h00, 0,   0, 8'h00, 16'h0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'h00, 16'h6000, 1, 8'h01));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'h01, 16'h6001, 1, 8'h02));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'h02, 16'h6002, 1, 8'h03));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'h03, 16'h6003, 1, 8'h04));
        // stall three cycles at pc=4
        tbl.push_back(v(0, 1, 0, 8'h00, 1,   1, 8'h04, 16'h6003, 1, 8'h04));
        tbl.push_back(v(0, 1, 0, 8'h00, 0,   0, 8'h00, 16'h6003, 1, 8'h04));
        tbl.push_back(v(0, 1, 0, 8'h00, 0,   0, 8'h00, 16'h6003, 1, 8'h04));
        tbl.push_back(v(0, 0, 0, 8'h00, 0,   0, 8'h00, 16'h6004, 1, 8'h05));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'h05, 16'h6005, 1, 8'h06));
        // redirect + stall together, then wrap FE -> FF -> 00
        tbl.push_back(v(0, 1, 1, 8'hFE, 1,   1, 8'h06, 16'h0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'hFE, 16'h60FE, 1, 8'hFF));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'hFF, 16'h60FF, 1, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'h00, 16'h6000, 1, 8'h01));
        // redirect to 10, then redirect to 40 while the read at 10 waits 3 cycles
        tbl.push_back(v(0, 0, 1, 8'h10, 1,   1, 8'h01, 16'h0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 0,   1, 8'h10, 16'h0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 1, 8'h40, 0,   1, 8'h10, 16'h0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 0,   1, 8'h10, 16'h0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'h10, 16'h0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 8'h40, 16'h6040, 1, 8'h41));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].ak, 1'b0);
            chk_row($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].instr,
                    tbl[i].valid, tbl[i].pc1);
        end

        // Reset while discarding, with the stale ack arriving during reset.
        step(0, 0, 1, 8'h80, 0, 1'b0); chk_row("rstdis_enter", 1, 8'h41, 16'h0000, 0, 8'h00);
        step(0, 0, 0, 8'h00, 0, 1'b0); chk_row("rstdis_wait",  1, 8'h41, 16'h0000, 0, 8'h00);
        step(1, 0, 0, 8'h00, 1, 1'b0); chk_row("rstdis_reset", 0, 8'h00, 16'h0000, 0, 8'h00);
        step(0, 0, 0, 8'h00, 0, 1'b0); chk_row("rstdis_after", 1, 8'h00, 16'h0000, 0, 8'h00);
        step(0, 0, 0, 8'h00, 1, 1'b0); chk_row("rstdis_fetch", 1, 8'h00, 16'h6000, 1, 8'h01);

        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, 8'($urandom), 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
